// File: rtl/dac_spi_tx.sv
// SPI mode-0 transmitter for a 24-bit DAC frame {CMD, sample}.
// Frame: LEAD, 24 SCLK bits, TRAIL, then a CS-high GAP before idle.
module dac_spi_tx #(
  parameter int unsigned CLK_DIV = 2,
  parameter logic [7:0]  CMD     = 8'h30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [16:0] data_in,
  input  logic        data_valid,
  output logic        busy,
  output logic        frame_done,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n,
  output logic [7:0]  drop_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL,
    GAP
  } state_e;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_e      state_q;
  logic [7:0]  div_q;
  logic [4:0]  bit_q;
  logic [23:0] shreg_q;
  logic        busy_q;
  logic        done_q;
  logic        sclk_q;
  logic        mosi_q;
  logic        cs_n_q;
  logic [7:0]  drop_q;

  logic        div_last;
  logic [23:0] word_d;

  assign div_last = (div_q == DIV_LAST);
  assign word_d   = {CMD, data_in[16] ? 16'hFFFF : data_in[15:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      drop_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (data_valid && busy_q && drop_q != 8'hFF)
        drop_q <= drop_q + 8'd1;
      case (state_q)
        IDLE: begin
          if (data_valid) begin
            state_q <= LEAD;
            busy_q  <= 1'b1;
            cs_n_q  <= 1'b0;
            shreg_q <= word_d;
            mosi_q  <= word_d[23];
            div_q   <= '0;
          end
        end
        LEAD: begin
          if (div_last) begin
            div_q   <= '0;
            bit_q   <= '0;
            state_q <= SHIFT;
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        SHIFT: begin
          if (div_last) begin
            div_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              // next bit is launched only on the falling edge
              if (bit_q == 5'd23) begin
                state_q <= TRAIL;
                mosi_q  <= 1'b0;
              end else begin
                bit_q   <= bit_q + 5'd1;
                shreg_q <= {shreg_q[22:0], 1'b0};
                mosi_q  <= shreg_q[22];
              end
            end
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        TRAIL: begin
          if (div_last) begin
            div_q   <= '0;
            cs_n_q  <= 1'b1;
            state_q <= GAP;
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        GAP: begin
          if (div_last) begin
            div_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign sclk       = sclk_q;
  assign mosi       = mosi_q;
  assign cs_n       = cs_n_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: two instances (CLK_DIV=2 and 1),
// each watched by a mode-0 SPI slave monitor that logs finished frames.
module tb_dac_spi_tx;

  logic        clk;
  logic        rst_n;
  logic [16:0] din_a, din_b;
  logic        val_a, val_b;
  logic        busy_a, done_a, sclk_a, mosi_a, csn_a;
  logic        busy_b, done_b, sclk_b, mosi_b, csn_b;
  logic [7:0]  drop_a, drop_b;

  int n_cmp = 0;
  int n_err = 0;

  dac_spi_tx #(.CLK_DIV(2), .CMD(8'h30)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(din_a), .data_valid(val_a),
    .busy(busy_a), .frame_done(done_a), .sclk(sclk_a), .mosi(mosi_a),
    .cs_n(csn_a), .drop_cnt(drop_a)
  );

  dac_spi_tx #(.CLK_DIV(1), .CMD(8'h30)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(din_b), .data_valid(val_b),
    .busy(busy_b), .frame_done(done_b), .sclk(sclk_b), .mosi(mosi_b),
    .cs_n(csn_b), .drop_cnt(drop_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // slave monitor A
  int          cyc_a = 0, fcnt_a = 0;
  logic [23:0] sh_a;
  int          nb_a, cs_a, bz_a, r1_a, rl_a;
  logic        sp_a;
  logic [23:0] w_a [32];
  int          nbq_a [32], csq_a [32], bzq_a [32], spn_a [32], dcy_a [32];

  always @(negedge clk) begin
    cyc_a <= cyc_a + 1;
    if (!rst_n) begin
      sh_a <= '0; nb_a <= 0; cs_a <= 0; bz_a <= 0; sp_a <= 1'b0;
      r1_a <= 0; rl_a <= 0;
    end else begin
      sp_a <= sclk_a;
      if (!csn_a) cs_a <= cs_a + 1;
      if (busy_a) bz_a <= bz_a + 1;
      if (sclk_a && !sp_a && !csn_a) begin
        sh_a <= {sh_a[22:0], mosi_a};
        nb_a <= nb_a + 1;
        if (nb_a == 0) r1_a <= cyc_a;
        rl_a <= cyc_a;
      end
      if (done_a) begin
        if (fcnt_a < 32) begin
          w_a[fcnt_a]   <= sh_a;
          nbq_a[fcnt_a] <= nb_a;
          csq_a[fcnt_a] <= cs_a;
          bzq_a[fcnt_a] <= bz_a;
          spn_a[fcnt_a] <= rl_a - r1_a;
          dcy_a[fcnt_a] <= cyc_a;
        end
        fcnt_a <= fcnt_a + 1;
        sh_a <= '0; nb_a <= 0; cs_a <= 0; bz_a <= 0;
      end
    end
  end

  // slave monitor B
  int          cyc_b = 0, fcnt_b = 0;
  logic [23:0] sh_b, w_b;
  int          nb_b, cs_b, bz_b, r1_b, rl_b;
  int          nbq_b, csq_b, bzq_b, spn_b;
  logic        sp_b;

  always @(negedge clk) begin
    cyc_b <= cyc_b + 1;
    if (!rst_n) begin
      sh_b <= '0; nb_b <= 0; cs_b <= 0; bz_b <= 0; sp_b <= 1'b0;
      r1_b <= 0; rl_b <= 0;
    end else begin
      sp_b <= sclk_b;
      if (!csn_b) cs_b <= cs_b + 1;
      if (busy_b) bz_b <= bz_b + 1;
      if (sclk_b && !sp_b && !csn_b) begin
        sh_b <= {sh_b[22:0], mosi_b};
        nb_b <= nb_b + 1;
        if (nb_b == 0) r1_b <= cyc_b;
        rl_b <= cyc_b;
      end
      if (done_b) begin
        w_b   <= sh_b;
        nbq_b <= nb_b;
        csq_b <= cs_b;
        bzq_b <= bz_b;
        spn_b <= rl_b - r1_b;
        fcnt_b <= fcnt_b + 1;
        sh_b <= '0; nb_b <= 0; cs_b <= 0; bz_b <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_a(input int n);
    for (int i = 0; i < 600 && fcnt_a < n; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic send_a(input string tag, input logic [16:0] d,
                        input logic [23:0] exp);
    int base;
    base  = fcnt_a;
    din_a = d;
    val_a = 1'b1;
    @(negedge clk);
    val_a = 1'b0;
    din_a = 17'h1FFFF;
    chk({tag, "_busy"}, 32'(busy_a), 1);
    chk({tag, "_csn"}, 32'(csn_a), 0);
    wait_a(base + 1);
    repeat (5) @(negedge clk);
    chk({tag, "_frames"}, fcnt_a, base + 1);
    chk({tag, "_word"}, 32'(w_a[base]), 32'(exp));
    chk({tag, "_bits"}, nbq_a[base], 24);
    chk({tag, "_cslow"}, csq_a[base], 100);
    chk({tag, "_busylen"}, bzq_a[base], 102);
    chk({tag, "_span"}, spn_a[base], 92);
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    din_a = '0; val_a = 1'b0;
    din_b = '0; val_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_sclk", 32'(sclk_a), 0);
    chk("rst_mosi", 32'(mosi_a), 0);
    chk("rst_csn", 32'(csn_a), 1);
    chk("rst_drop", 32'(drop_a), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send_a("single", 17'd16384, 24'h304000);
    chk("single_drop", 32'(drop_a), 0);
    send_a("sat81919", 17'd81919, 24'h30FFFF);
    send_a("sat65535", 17'd65535, 24'h30FFFF);
    send_a("zero", 17'd0, 24'h300000);

    // continuous valid with ramp: accepts at 0, 103, 206
    base = fcnt_a;
    for (int i = 0; i < 306; i++) begin
      din_a = 17'(1000 + i);
      val_a = 1'b1;
      @(negedge clk);
    end
    val_a = 1'b0;
    wait_a(base + 3);
    chk("ramp_frames", fcnt_a, base + 3);
    chk("ramp_w0", 32'(w_a[base]), 32'h3003E8);
    chk("ramp_w1", 32'(w_a[base + 1]), 32'h30044F);
    chk("ramp_w2", 32'(w_a[base + 2]), 32'h3004B6);
    chk("ramp_gap01", dcy_a[base + 1] - dcy_a[base], 103);
    chk("ramp_gap12", dcy_a[base + 2] - dcy_a[base + 1], 103);
    chk("ramp_busy2", bzq_a[base + 2], 102);
    chk("ramp_drop", 32'(drop_a), 32'hFF);

    // reset 40 cycles into a frame
    base  = fcnt_a;
    din_a = 17'h01234;
    val_a = 1'b1;
    @(negedge clk);
    val_a = 1'b0;
    repeat (39) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_csn", 32'(csn_a), 1);
    chk("abort_sclk", 32'(sclk_a), 0);
    chk("abort_busy", 32'(busy_a), 0);
    chk("abort_drop", 32'(drop_a), 0);
    repeat (3) begin
      @(posedge clk);
      #1 chk("abort_hold_sclk", 32'(sclk_a), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_noframe", fcnt_a, base);
    send_a("postrst", 17'h00ABC, 24'h300ABC);

    // drop_cnt saturation
    base = fcnt_a;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) chk("drop_mid", 32'(drop_a), 198);
      din_a = 17'd5;
      val_a = 1'b1;
      @(negedge clk);
    end
    val_a = 1'b0;
    wait_a(base + 4);
    chk("drop_frames", fcnt_a, base + 4);
    chk("drop_sat", 32'(drop_a), 32'hFF);
    chk("drop_word", 32'(w_a[base + 3]), 32'h300005);

    // CLK_DIV = 1 instance
    din_b = 17'h05A5A;
    val_b = 1'b1;
    @(negedge clk);
    val_b = 1'b0;
    din_b = '0;
    for (int i = 0; i < 200 && fcnt_b < 1; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("div1_frames", fcnt_b, 1);
    chk("div1_word", 32'(w_b), 32'h305A5A);
    chk("div1_bits", nbq_b, 24);
    chk("div1_busylen", bzq_b, 51);
    chk("div1_cslow", csq_b, 50);
    chk("div1_span", spn_b, 46);
    chk("div1_drop", 32'(drop_b), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
